iob_mem_arbiter: RTL and testbench

IOB_MEM_ARBITER -- requirements
Module: iob_mem_arbiter

---
 rtl/iob_mem_arb_pkg.sv | 17 +
 rtl/iob_mem_arb_pick.sv | 33 +++
 rtl/iob_mem_arbiter.sv | 109 ++++++++++
 tb/tb_iob_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_mem_arb_pkg.sv
// Shared FSM state encoding and requester indices for the two-port memory arbiter.
// Optional round-robin arbitration is selected with IOB_MEM_ARB_RR_EN.
package iob_mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/iob_mem_arb_pick.sv
// Combinational winner select between two requesters; fixed priority to REQ0,
// or round-robin against the last grant when IOB_MEM_ARB_RR_EN is defined.
module iob_mem_arb_pick
    import iob_mem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       winner_o
);

`ifdef IOB_MEM_ARB_RR_EN
    always_comb begin
        winner_o = REQ0;
        if (valid_i == 2'b10) begin
            winner_o = REQ1;
        end else if (valid_i == 2'b11) begin
            winner_o = other_req(last_grant_i);
        end
    end
`else
    // Fixed priority never looks at history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        winner_o = REQ0;
        if (valid_i == 2'b10) begin
            winner_o = REQ1;
        end
    end
`endif

endmodule

// File: rtl/iob_mem_arbiter.sv
// Two-requester arbiter onto one native memory port: request captured in IDLE, mem_valid
// one cycle later, ready passed through combinationally. Round-robin with IOB_MEM_ARB_RR_EN.
module iob_mem_arbiter
    import iob_mem_arb_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    localparam int N_BYTES = DATA_W / 8
)(
    input  logic               clk,
    input  logic               reset,

    input  logic               req0_valid,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic [DATA_W-1:0]  req0_wdata,
    input  logic [N_BYTES-1:0] req0_wstrb,
    output logic [DATA_W-1:0]  req0_rdata,
    output logic               req0_ready,

    input  logic               req1_valid,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic [DATA_W-1:0]  req1_wdata,
    input  logic [N_BYTES-1:0] req1_wstrb,
    output logic [DATA_W-1:0]  req1_rdata,
    output logic               req1_ready,

    output logic               mem_valid,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [N_BYTES-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ready,

    output logic               grant
);

    arb_state_e         state_q;
    logic               mem_valid_q;
    logic               grant_q;
    logic               last_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [N_BYTES-1:0] wstrb_q;

    logic               winner;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic [N_BYTES-1:0] wstrb_d;
    logic               busy;

    iob_mem_arb_pick u_pick (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_q),
        .winner_o     (winner)
    );

    assign addr_d  = (winner == REQ1) ? req1_addr  : req0_addr;
    assign wdata_d = (winner == REQ1) ? req1_wdata : req0_wdata;
    assign wstrb_d = (winner == REQ1) ? req1_wstrb : req0_wstrb;

    // last_q resets to REQ1 so that requester 0 wins the first contested round.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            grant_q     <= REQ0;
            last_q      <= REQ1;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state_q     <= ST_BUSY;
                        mem_valid_q <= 1'b1;
                        grant_q     <= winner;
                        last_q      <= winner;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        wstrb_q     <= wstrb_d;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        state_q     <= ST_IDLE;
                        mem_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = (state_q == ST_BUSY);

    assign mem_valid = mem_valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign grant     = grant_q;

    // A reset cycle abandons the transaction, so a coincident mem_ready must not complete it.
    assign req0_ready = busy && !reset && mem_ready && (grant_q == REQ0);
    assign req1_ready = busy && !reset && mem_ready && (grant_q == REQ1);

    assign req0_rdata = mem_rdata;
    assign req1_rdata = mem_rdata;

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Bench for iob_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model and a behavioural backend memory.
module tb_iob_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = DW / 8;
`ifdef IOB_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic [NB-1:0] req0_wstrb, req1_wstrb;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          req0_ready, req1_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [NB-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          grant;

    always #5 clk = ~clk;

    iob_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_wstrb(req0_wstrb), .req0_rdata(req0_rdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_wstrb(req1_wstrb), .req1_rdata(req1_rdata), .req1_ready(req1_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, captured fields, last winner.
    bit        m_busy, m_owner, m_last;
    bit [31:0] m_addr, m_wdata;
    bit [3:0]  m_wstrb;
    bit [31:0] ref_mem [bit [31:0]];
    bit [31:0] bmem    [bit [31:0]];

    bit        be_random;
    bit        be_prev_rdy;
    int        be_force;
    logic      seen_rdy0, seen_rdy1;
    logic [31:0] obs_rdata1;
    bit        done_log[$];

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] s);
        bit [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic set_req(input int idx, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (idx == 0) begin
            req0_valid = v; req0_addr = a; req0_wdata = d; req0_wstrb = s;
        end else begin
            req1_valid = v; req1_addr = a; req1_wdata = d; req1_wstrb = s;
        end
    endtask

    // One clock: backend response, checks, then model update on the edge.
    task automatic cycle();
        bit w, completion;
        if (be_force >= 0)  mem_ready = be_force[0];
        else if (be_random) mem_ready = mem_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
        else                mem_ready = mem_valid && !be_prev_rdy;
        be_prev_rdy = mem_ready;
        mem_rdata = (mem_valid && bmem.exists(mem_addr)) ? bmem[mem_addr] : $urandom;
        #1;
        completion = m_busy && !reset && mem_ready;
        chk("mem_valid", mem_valid, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wstrb", mem_wstrb, m_wstrb);
        end
        chk("grant", grant, m_owner);
        chk("req0_ready", req0_ready, completion && m_owner == 1'b0);
        chk("req1_ready", req1_ready, completion && m_owner == 1'b1);
        chk("req0_rdata", req0_rdata, mem_rdata);
        chk("req1_rdata", req1_rdata, mem_rdata);
        if (completion && m_wstrb == 4'h0)
            chk("read_data", m_owner ? req1_rdata : req0_rdata, ref_mem[m_addr]);
        seen_rdy0 = req0_ready;
        seen_rdy1 = req1_ready;
        if (req1_ready) obs_rdata1 = req1_rdata;
        if (req0_ready) done_log.push_back(1'b0);
        if (req1_ready) done_log.push_back(1'b1);
        if (mem_valid && mem_ready && mem_wstrb != '0 && bmem.exists(mem_addr))
            bmem[mem_addr] = merge(bmem[mem_addr], mem_wdata, mem_wstrb);
        if (completion && m_wstrb != 4'h0)
            ref_mem[m_addr] = merge(ref_mem[m_addr], m_wdata, m_wstrb);
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_owner = 0; m_last = 1;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                if (req0_valid && req1_valid) w = RR ? !m_last : 1'b0;
                else                          w = req1_valid;
                m_busy = 1; m_owner = w; m_last = w;
                m_addr  = w ? req1_addr  : req0_addr;
                m_wdata = w ? req1_wdata : req0_wdata;
                m_wstrb = w ? req1_wstrb : req0_wstrb;
            end
        end else if (mem_ready) begin
            m_busy = 0;
        end
        @(negedge clk);
    endtask

    task automatic run_until_ready(input int idx, input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(idx == 0 ? seen_rdy0 : seen_rdy1) && n < budget);
        chk("ready_seen", idx == 0 ? seen_rdy0 : seen_rdy1, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_seq [4];
        int n;
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        mem_ready = 0; mem_rdata = 0;
        be_random = 0; be_prev_rdy = 0; be_force = -1;
        m_busy = 0; m_owner = 0; m_last = 1;
        for (int a = 0; a < 16; a++) begin
            bit [31:0] v = $urandom;
            ref_mem[a*4] = v; bmem[a*4] = v;
        end
        ref_mem[32'h1234] = 0; bmem[32'h1234] = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        cycle();
        reset = 1'b0;
        cycle();

        // Write from requester 0, then read it back through requester 1.
        set_req(0, 1, 32'h1234, 32'hDEADBEEF, 4'hF);
        cycle();
        chk("lat_mem_valid", mem_valid, 1'b1);
        chk("lat_mem_addr", mem_addr, 32'h1234);
        chk("lat_mem_wdata", mem_wdata, 32'hDEADBEEF);
        run_until_ready(0, 10);
        chk("wr_req1_quiet", seen_rdy1, 1'b0);
        set_req(0, 0, 0, 0, 0);

        set_req(1, 1, 32'h1234, 32'h0, 4'h0);
        run_until_ready(1, 10);
        chk("rd_1234", obs_rdata1, 32'hDEADBEEF);
        set_req(1, 0, 0, 0, 0);

        // Live address changes while the captured copy is in flight.
        set_req(0, 1, 32'h1234, 32'h11, 4'h1);
        cycle();
        req0_addr = 32'h0;
        chk("hold_addr_a", mem_addr, 32'h1234);
        cycle();
        chk("hold_addr_b", mem_addr, 32'h1234);
        run_until_ready(0, 10);
        set_req(0, 0, 0, 0, 0);
        cycle();

        // Both requesters held valid across four transactions.
        exp_seq = RR ? '{1'b0, 1'b1, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b0};
        done_log.delete();
        set_req(0, 1, 32'h10, 0, 0);
        set_req(1, 1, 32'h14, 0, 0);
        n = 0;
        while (done_log.size() < 4 && n < 40) begin
            cycle();
            n++;
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_seq%0d", i), (i < done_log.size()) ? {1'b0, done_log[i]} : 2'h3, {1'b0, exp_seq[i]});
        while (m_busy && n < 60) begin
            cycle();
            n++;
        end
        cycle();

        // Reset in the middle of a transaction, with mem_ready during and after it.
        set_req(1, 1, 32'h20, 0, 0);
        cycle();
        set_req(1, 0, 0, 0, 0);
        chk("pre_rst_busy", mem_valid, 1'b1);
        reset = 1'b1;
        be_force = 1;
        cycle();
        chk("rst_busy_no_rdy_a", seen_rdy1, 1'b0);
        reset = 1'b0;
        cycle();
        chk("rst_busy_no_rdy_b", seen_rdy1, 1'b0);
        chk("rst_busy_mem_valid", mem_valid, 1'b0);
        chk("rst_busy_grant", grant, 1'b0);
        be_force = -1;
        be_prev_rdy = 0;

        // Randomized traffic.
        be_random = 1;
        for (int c = 0; c < 1500; c++) begin
            if (seen_rdy0) req0_valid = 0;
            else if (!req0_valid && $urandom_range(0, 2) == 0)
                set_req(0, 1, {$urandom_range(0, 15), 2'b00}, $urandom,
                        ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
            else if (req0_valid && m_busy && !m_owner && $urandom_range(0, 3) == 0) begin
                req0_addr = {$urandom_range(0, 15), 2'b00}; req0_wdata = $urandom;
            end
            if (seen_rdy1) req1_valid = 0;
            else if (!req1_valid && $urandom_range(0, 2) == 0)
                set_req(1, 1, {$urandom_range(0, 15), 2'b00}, $urandom,
                        ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
            else if (req1_valid && m_busy && m_owner && $urandom_range(0, 3) == 0) begin
                req1_addr = {$urandom_range(0, 15), 2'b00}; req1_wdata = $urandom;
            end
            cycle();
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        n = 0;
        while (m_busy && n < 50) begin
            cycle();
            n++;
        end
        chk("drain_idle", m_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
